// File: rtl/count_pkg.sv
// Shared definitions for the count_param counter family: operation codes,
// parameter legality limits and small mode-decoding helpers.
package count_pkg;

    // Operation select width and encodings
    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_UP1    = 3'b000;
    localparam logic [MODE_W-1:0] MODE_DN1    = 3'b001;
    localparam logic [MODE_W-1:0] MODE_DNSTEP = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_UPSTEP = 3'b100;
    localparam logic [MODE_W-1:0] MODE_HOLD   = 3'b101;

    // Legal parameter ranges
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned STEP_MIN  = 1;

    // WIDTH must lie within the supported range
    function automatic bit width_legal(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // STEP must be non-zero and representable in WIDTH bits
    function automatic bit step_legal(input int unsigned w, input int unsigned s);
        longint unsigned max_val;
        max_val = (64'(1) << w) - 64'(1);
        return (s >= STEP_MIN) && (64'(s) <= max_val);
    endfunction

    // SATURATE is a 0/1 switch
    function automatic bit sat_legal(input int unsigned sat);
        return sat <= 1;
    endfunction

    // Counting modes are the ones gated by the cascade carry-in
    function automatic bit is_count_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_UP1) || (m == MODE_DN1) ||
               (m == MODE_DNSTEP) || (m == MODE_UPSTEP);
    endfunction

    // Counting direction (only meaningful for counting modes)
    function automatic bit is_up_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_UP1) || (m == MODE_UPSTEP);
    endfunction

    // Magnitude selector: STEP versus 1
    function automatic bit is_step_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_DNSTEP) || (m == MODE_UPSTEP);
    endfunction

endpackage

// File: rtl/count_step_unit.sv
// Combinational next-value generator for count_param.
// Ports:
//   q      - current count
//   modo   - operation select
//   next_q - count after the selected operation (LOAD/HOLD return q;
//            the load value is muxed in by the parent)
//   evt    - wrap, clamp or load event
//   clamp  - result was clamped to 0 / all-ones (SATURATE=1 only)
module count_step_unit
    import count_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP     = 3,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [MODE_W-1:0] modo,
    output logic [WIDTH-1:0]  next_q,
    output logic              evt,
    output logic              clamp
);

    localparam int unsigned EXT_W = WIDTH + 1;
    localparam logic [EXT_W-1:0] K_ONE  = EXT_W'(1);
    localparam logic [EXT_W-1:0] K_STEP = EXT_W'(STEP);
    localparam bit SAT_EN = (SATURATE != 0);

    logic [EXT_W-1:0] q_ext;
    logic [EXT_W-1:0] k;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] diff;
    logic             up;
    logic             active;

    // One extra bit exposes overflow (sum) and borrow (diff) directly
    assign q_ext  = {1'b0, q};
    assign k      = is_step_mode(modo) ? K_STEP : K_ONE;
    assign sum    = q_ext + k;
    assign diff   = q_ext - k;
    assign up     = is_up_mode(modo);
    assign active = is_count_mode(modo);

    // Wrap or clamp the arithmetic result and flag the event
    always_comb begin
        next_q = q;
        evt    = 1'b0;
        clamp  = 1'b0;
        if (modo == MODE_LOAD) begin
            evt = 1'b1;
        end else if (active) begin
            if (up) begin
                next_q = sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    evt = 1'b1;
                    if (SAT_EN) begin
                        next_q = '1;
                        clamp  = 1'b1;
                    end
                end
            end else begin
                next_q = diff[WIDTH-1:0];
                if (diff[WIDTH]) begin
                    evt = 1'b1;
                    if (SAT_EN) begin
                        next_q = '0;
                        clamp  = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/count_param.sv
// Parametrised up/down/step/load counter with cascade carry-in, registered
// ripple-carry-out and optional saturation.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-low reset, wins over everything
//   enable - 0 freezes Q, rco and sat
//   ci     - cascade carry-in, gates the counting modes only
//   modo   - operation select (see count_pkg)
//   D      - parallel load value
//   Q      - registered count
//   rco    - registered one-cycle event flag (wrap, clamp or load)
//   sat    - registered clamp indicator (always 0 when SATURATE=0)
module count_param
    import count_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STEP     = 3,
    parameter int unsigned SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              ci,
    input  logic [MODE_W-1:0] modo,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  Q,
    output logic              rco,
    output logic              sat
);

    // Elaboration-time parameter checks
    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("count_param: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (!step_legal(WIDTH, STEP)) begin : g_bad_step
        $error("count_param: STEP=%0d not in 1..2^WIDTH-1", STEP);
    end
    if (!sat_legal(SATURATE)) begin : g_bad_sat
        $error("count_param: SATURATE=%0d must be 0 or 1", SATURATE);
    end

    logic [WIDTH-1:0] step_q;
    logic             step_evt;
    logic             step_clamp;
    logic [WIDTH-1:0] q_d;
    logic             rco_d;
    logic             sat_d;

    count_step_unit #(
        .WIDTH   (WIDTH),
        .STEP    (STEP),
        .SATURATE(SATURATE)
    ) u_step (
        .q     (Q),
        .modo  (modo),
        .next_q(step_q),
        .evt   (step_evt),
        .clamp (step_clamp)
    );

    // Next-state selection: load mux plus carry-in gating of counting modes
    always_comb begin
        q_d   = Q;
        rco_d = 1'b0;
        sat_d = sat;
        if (modo == MODE_LOAD) begin
            q_d   = D;
            rco_d = step_evt;
            sat_d = 1'b0;
        end else if (is_count_mode(modo) && ci) begin
            q_d   = step_q;
            rco_d = step_evt;
            sat_d = step_clamp;
        end
    end

    // State registers; enable=0 freezes everything including an rco pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            Q   <= '0;
            rco <= 1'b0;
            sat <= 1'b0;
        end else if (enable) begin
            Q   <= q_d;
            rco <= rco_d;
            sat <= sat_d;
        end
    end

endmodule
